// File: rtl/wb_arb.sv
// Writeback arbiter: merges pipeline writebacks and a 2-deep queue of aux-unit results onto one GRF write port.
// Optional macro WB_ARB_BYPASS_EN lets an aux transfer write straight through when the queue is empty and the port is free.
module wb_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        aux_valid,
  input  logic [4:0]  aux_wa,
  input  logic [31:0] aux_wd,
  output logic        aux_ready,
  output logic        WE,
  output logic [4:0]  WA,
  output logic [31:0] WD,
  output logic        pipe_stall,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_pending,
  output logic        rt_pending
);

  typedef enum logic [1:0] {IDLE, QUEUED, FORCE} state_e;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  ent_t [1:0]  fifo_q, fifo_d;
  logic [1:0]  count_q, count_d, count_mid;
  logic [3:0]  age_q, age_d;
  logic        aux_fire, bypass, enq, grant_pipe, grant_aux;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      fifo_q  <= '0;
      count_q <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      fifo_q  <= fifo_d;
      count_q <= count_d;
      age_q   <= age_d;
    end
  end

  // Grant and port drive; the state is registered so stall/ready never depend on inputs.
  always_comb begin
    aux_ready  = ~count_q[1];
    pipe_stall = (state_q == FORCE);
    aux_fire   = aux_valid && aux_ready && (aux_wa != 5'd0);
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    case (state_q)
      FORCE:   grant_aux = 1'b1;
      default: begin
        if (pipe_we && (pipe_wa != 5'd0)) grant_pipe = 1'b1;
        else if (count_q != 2'd0)         grant_aux  = 1'b1;
      end
    endcase
`ifdef WB_ARB_BYPASS_EN
    bypass = aux_fire && (count_q == 2'd0) && (state_q != FORCE) && !grant_pipe;
`else
    bypass = 1'b0;
`endif
    enq = aux_fire && !bypass;
    WE  = 1'b0;
    WA  = 5'd0;
    WD  = 32'd0;
    if (rst) begin
      if (grant_pipe) begin
        WE = 1'b1; WA = pipe_wa; WD = pipe_wd;
      end else if (grant_aux) begin
        WE = 1'b1; WA = fifo_q[0].wa; WD = fifo_q[0].wd;
      end else if (bypass) begin
        WE = 1'b1; WA = aux_wa; WD = aux_wd;
      end
    end
  end

  // Queue update: dequeue shifts entry 1 to the head, then the new entry lands behind what remains.
  always_comb begin
    fifo_d    = fifo_q;
    count_mid = count_q - {1'b0, grant_aux};
    if (grant_aux) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = '0;
    end
    if (enq) fifo_d[count_mid[0]] = {aux_wa, aux_wd};
    count_d = count_mid + {1'b0, enq};

    if ((count_q == 2'd0) || grant_aux) age_d = 4'd0;
    else if (age_q < LIMIT)             age_d = age_q + 4'd1;
    else                                age_d = age_q;

    if (count_d == 2'd0)     state_d = IDLE;
    else if (age_d >= LIMIT) state_d = FORCE;
    else                     state_d = QUEUED;
  end

  always_comb begin
    rs_pending = (rs_addr != 5'd0) &&
                 (((count_q != 2'd0) && (fifo_q[0].wa == rs_addr)) ||
                  ((count_q == 2'd2) && (fifo_q[1].wa == rs_addr)));
    rt_pending = (rt_addr != 5'd0) &&
                 (((count_q != 2'd0) && (fifo_q[0].wa == rt_addr)) ||
                  ((count_q == 2'd2) && (fifo_q[1].wa == rt_addr)));
  end

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: reset, queue latency, starvation stall, full queue, discard, mid-run reset, swap.
module tb_wb_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, aux_valid, aux_ready, WE, pipe_stall, rs_pending, rt_pending;
  logic [4:0]  pipe_wa, aux_wa, WA, rs_addr, rt_addr;
  logic [31:0] pipe_wd, aux_wd, WD;
  int n_chk = 0;
  int n_fail = 0;

  wb_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .aux_valid(aux_valid), .aux_wa(aux_wa), .aux_wd(aux_wd), .aux_ready(aux_ready),
    .WE(WE), .WA(WA), .WD(WD), .pipe_stall(pipe_stall),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pending(rs_pending), .rt_pending(rt_pending)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    aux_valid = 0; aux_wa = 0; aux_wd = 0;
    rs_addr = 0; rt_addr = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle_inputs();
    tick(); tick();
    rst = 1; rs_addr = 5; rt_addr = 5; #1;
    n_chk++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", aux_ready); end
    n_chk++; if (pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", pipe_stall); end
    n_chk++; if ({WE, WA, WD} !== 38'd0) begin n_fail++; $display("FAIL reset_port got %0b/%0d/%h want 0/0/0", WE, WA, WD); end
    n_chk++; if ({rs_pending, rt_pending} !== 2'b00) begin n_fail++; $display("FAIL reset_pending got %b want 00", {rs_pending, rt_pending}); end
    tick();
  endtask

  task automatic test_basic();
    idle_inputs();
    aux_valid = 1; aux_wa = 5; aux_wd = 32'h11; rs_addr = 5; #1;
`ifdef WB_ARB_BYPASS_EN
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd5, 32'h11}) begin n_fail++; $display("FAIL basic_bypass got %0b/%0d/%h want 1/5/11", WE, WA, WD); end
    tick(); aux_valid = 0; #1;
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL basic_after got %0b want 0", WE); end
`else
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL basic_same_cycle got %0b want 0", WE); end
    tick(); aux_valid = 0; #1;
    n_chk++; if (rs_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending got %0b want 1", rs_pending); end
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd5, 32'h11}) begin n_fail++; $display("FAIL basic_write got %0b/%0d/%h want 1/5/11", WE, WA, WD); end
    tick();
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %0b want 0", WE); end
`endif
    n_chk++; if (rs_pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_clr got %0b want 0", rs_pending); end
  endtask

  task automatic test_starve();
    int stalls = 0;
    idle_inputs();
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h70;
    aux_valid = 1; aux_wa = 3; aux_wd = 32'h33; #1;
    n_chk++; if ({WE, WA} !== {1'b1, 5'd7}) begin n_fail++; $display("FAIL starve_c0 got %0b/%0d want 1/7", WE, WA); end
    tick(); aux_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      pipe_wd = 32'h70 + i; #1;
      if (pipe_stall) stalls++;
      n_chk++; if (pipe_stall !== (i == 5)) begin n_fail++; $display("FAIL starve_stall c%0d got %0b want %0b", i, pipe_stall, (i == 5)); end
      n_chk++; if ({WE, WA} !== {1'b1, (i == 5) ? 5'd3 : 5'd7}) begin n_fail++; $display("FAIL starve_wa c%0d got %0b/%0d want 1/%0d", i, WE, WA, (i == 5) ? 3 : 7); end
      tick();
    end
    n_chk++; if (stalls !== 1) begin n_fail++; $display("FAIL starve_count got %0d want 1", stalls); end
    pipe_we = 0; #1;
    n_chk++; if ({WE, pipe_stall} !== 2'b00) begin n_fail++; $display("FAIL starve_end got %b want 00", {WE, pipe_stall}); end
  endtask

  task automatic test_full();
    idle_inputs();
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h7;
    aux_valid = 1; aux_wa = 1; aux_wd = 32'hA; tick();
    aux_wa = 2; aux_wd = 32'hB; #1;
    n_chk++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready1 got %0b want 1", aux_ready); end
    tick();
    aux_wa = 4; aux_wd = 32'hC; #1;
    n_chk++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready2 got %0b want 0", aux_ready); end
    n_chk++; if (WA !== 5'd7) begin n_fail++; $display("FAIL full_pipe got %0d want 7", WA); end
    tick();
    pipe_we = 0; rt_addr = 2; #1;
    n_chk++; if (aux_ready !== 1'b0) begin n_fail++; $display("FAIL full_held got %0b want 0", aux_ready); end
    n_chk++; if (rt_pending !== 1'b1) begin n_fail++; $display("FAIL full_rt_pend got %0b want 1", rt_pending); end
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd1, 32'hA}) begin n_fail++; $display("FAIL full_deq1 got %0b/%0d/%h want 1/1/a", WE, WA, WD); end
    tick(); #1;
    n_chk++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready3 got %0b want 1", aux_ready); end
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd2, 32'hB}) begin n_fail++; $display("FAIL full_deq2 got %0b/%0d/%h want 1/2/b", WE, WA, WD); end
    tick(); aux_valid = 0; #1;
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd4, 32'hC}) begin n_fail++; $display("FAIL full_deq3 got %0b/%0d/%h want 1/4/c", WE, WA, WD); end
    tick();
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL full_empty got %0b want 0", WE); end
  endtask

  task automatic test_discard();
    idle_inputs();
    aux_valid = 1; aux_wa = 0; aux_wd = 32'hFFFF; #1;
    n_chk++; if (aux_ready !== 1'b1) begin n_fail++; $display("FAIL discard_ready got %0b want 1", aux_ready); end
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL discard_we0 got %0b want 0", WE); end
    tick(); aux_valid = 0; pipe_we = 1; pipe_wa = 0; pipe_wd = 32'h55; #1;
    n_chk++; if ({WE, WA} !== 6'd0) begin n_fail++; $display("FAIL discard_we1 got %0b/%0d want 0/0", WE, WA); end
    tick(); pipe_we = 0; #1;
    n_chk++; if ({WE, aux_ready} !== 2'b01) begin n_fail++; $display("FAIL discard_cnt got %b want 01", {WE, aux_ready}); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h7;
    aux_valid = 1; aux_wa = 10; aux_wd = 32'hAA; tick();
    aux_wa = 11; aux_wd = 32'hBB; tick();
    aux_valid = 0; pipe_we = 0; rst = 0; #1;
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL rmid_during got %0b want 0", WE); end
    tick();
    rst = 1; rs_addr = 10; rt_addr = 11; #1;
    n_chk++; if ({WE, pipe_stall, aux_ready} !== 3'b001) begin n_fail++; $display("FAIL rmid_after got %b want 001", {WE, pipe_stall, aux_ready}); end
    n_chk++; if ({rs_pending, rt_pending} !== 2'b00) begin n_fail++; $display("FAIL rmid_pend got %b want 00", {rs_pending, rt_pending}); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL rmid_drain c%0d got %0b want 0", i, WE); end
    end
  endtask

  task automatic test_swap();
    idle_inputs();
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h7;
    aux_valid = 1; aux_wa = 8; aux_wd = 32'h80; tick();
    pipe_we = 0; aux_wa = 9; aux_wd = 32'h99; rs_addr = 9; rt_addr = 8; #1;
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd8, 32'h80}) begin n_fail++; $display("FAIL swap_head got %0b/%0d/%h want 1/8/80", WE, WA, WD); end
    n_chk++; if ({aux_ready, rs_pending, rt_pending} !== 3'b101) begin n_fail++; $display("FAIL swap_flags got %b want 101", {aux_ready, rs_pending, rt_pending}); end
    tick(); aux_valid = 0; #1;
    n_chk++; if ({WE, WA, WD} !== {1'b1, 5'd9, 32'h99}) begin n_fail++; $display("FAIL swap_new got %0b/%0d/%h want 1/9/99", WE, WA, WD); end
    n_chk++; if ({rs_pending, rt_pending} !== 2'b10) begin n_fail++; $display("FAIL swap_pend got %b want 10", {rs_pending, rt_pending}); end
    tick();
    n_chk++; if (WE !== 1'b0) begin n_fail++; $display("FAIL swap_empty got %0b want 0", WE); end
  endtask

  initial begin
    test_reset();
    test_basic();
    tick();
    test_starve();
    tick();
    test_full();
    tick();
    test_discard();
    tick();
    test_reset_mid();
    tick();
    test_swap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
